seg_scan_ctrl: RTL and testbench

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

---
 rtl/seg_scan_ctrl.sv | 121 ++++++++++++
 tb/tb_seg_scan_ctrl.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/seg_scan_ctrl.sv
// Six-digit multiplexed 7-segment scan controller (common anode, active-low segments).
// Captures one consistent snapshot per frame and applies leading-zero blanking, sign and decimal points.
module seg_scan_ctrl #(
    parameter int unsigned CNT_MAX = 49_999
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic [3:0] unit,
    input  logic [3:0] ten,
    input  logic [3:0] hun,
    input  logic [3:0] tho,
    input  logic [3:0] t_tho,
    input  logic [3:0] h_tho,
    input  logic [5:0] point,
    input  logic       sign,
    input  logic       seg_en,
    output logic [5:0] sel,
    output logic [7:0] seg
);

    localparam int unsigned CW = ($clog2(CNT_MAX + 1) > 0) ? $clog2(CNT_MAX + 1) : 1;

    logic [CW-1:0]  cnt_q, cnt_d;
    logic [2:0]     idx_q, idx_d;
    logic [5:0][3:0] dig_q, dig_d;
    logic [5:0]     pnt_q, pnt_d;
    logic           sgn_q, sgn_d;
    logic [5:0]     sel_q, sel_d;
    logic [7:0]     seg_q, seg_d;

    logic           last_cnt;
    logic           load;
    logic [2:0]     msd;
    logic [3:0]     cur_dig;
    logic [7:0]     enc;

    function automatic logic [7:0] bcd_to_seg(input logic [3:0] d);
        logic [7:0] s;
        case (d)
            4'd0:    s = 8'hC0;
            4'd1:    s = 8'hF9;
            4'd2:    s = 8'hA4;
            4'd3:    s = 8'hB0;
            4'd4:    s = 8'h99;
            4'd5:    s = 8'h92;
            4'd6:    s = 8'h82;
            4'd7:    s = 8'hF8;
            4'd8:    s = 8'h80;
            4'd9:    s = 8'h90;
            default: s = 8'hFF;
        endcase
        return s;
    endfunction

    // Encoding of the digit currently selected, taken from the frame snapshot.
    always_comb begin
        msd = '0;
        for (int unsigned i = 0; i < 6; i++) begin
            if (dig_q[i] != 4'd0) msd = 3'(i);
        end
        cur_dig = dig_q[idx_q];
        if (idx_q > msd) begin
            enc = (sgn_q && (idx_q == 3'(msd + 3'd1))) ? 8'hBF : 8'hFF;
        end else begin
            enc = bcd_to_seg(cur_dig);
        end
        if (pnt_q[idx_q]) enc[7] = 1'b0;
    end

    always_comb begin
        last_cnt = (cnt_q == CW'(CNT_MAX));
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        load     = 1'b0;
        sel_d    = '0;
        seg_d    = '1;
        if (!seg_en) begin
            cnt_d = '0;
            idx_d = '0;
            load  = 1'b1;
        end else begin
            cnt_d = last_cnt ? '0 : cnt_q + 1'b1;
            if (last_cnt) idx_d = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
            load  = last_cnt && (idx_q == 3'd5);
            sel_d = 6'b000001 << idx_q;
            seg_d = enc;
        end
        dig_d = dig_q;
        pnt_d = pnt_q;
        sgn_d = sgn_q;
        if (load) begin
            dig_d = {h_tho, t_tho, tho, hun, ten, unit};
            pnt_d = point;
            sgn_d = sign;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt_q <= '0;
            idx_q <= '0;
            dig_q <= '0;
            pnt_q <= '0;
            sgn_q <= 1'b0;
            sel_q <= '0;
            seg_q <= '1;
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
            dig_q <= dig_d;
            pnt_q <= pnt_d;
            sgn_q <= sgn_d;
            sel_q <= sel_d;
            seg_q <= seg_d;
        end
    end

    assign sel = sel_q;
    assign seg = seg_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with CNT_MAX=4 (5 clocks per digit, 30 per frame).
module tb_seg_scan_ctrl;

    logic       clk;
    logic       rst_n;
    logic [3:0] unit, ten, hun, tho, t_tho, h_tho;
    logic [5:0] point;
    logic       sign;
    logic       seg_en;
    logic [5:0] sel;
    logic [7:0] seg;

    int checks   = 0;
    int failures = 0;

    seg_scan_ctrl #(.CNT_MAX(4)) dut (
        .sys_clk  (clk),
        .sys_rst_n(rst_n),
        .unit     (unit),
        .ten      (ten),
        .hun      (hun),
        .tho      (tho),
        .t_tho    (t_tho),
        .h_tho    (h_tho),
        .point    (point),
        .sign     (sign),
        .seg_en   (seg_en),
        .sel      (sel),
        .seg      (seg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] dig;
        logic [5:0]  pt;
        logic        sg;
        logic [47:0] exp;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setv(input logic [23:0] d, input logic [5:0] p, input logic s);
        {h_tho, t_tho, tho, hun, ten, unit} = d;
        point = p;
        sign  = s;
    endtask

    // Expects idx_q=0, cnt_q=0 and seg_en=1 before the first edge.
    task automatic run_frame(input string name, input logic [47:0] exp);
        for (int e = 0; e < 30; e++) begin
            tick();
            chk({name, "_sel"}, {2'b00, sel}, {2'b00, 6'b000001 << (e / 5)});
            chk({name, "_seg"}, seg, exp[8*(e/5) +: 8]);
        end
    endtask

    initial begin
        vecs[0] = '{24'h987360, 6'b000000, 1'b0, 48'h90_80_F8_B0_82_C0};
        vecs[1] = '{24'h000489, 6'b000000, 1'b0, 48'hFF_FF_FF_99_80_90};
        vecs[2] = '{24'h000000, 6'b000000, 1'b0, 48'hFF_FF_FF_FF_FF_C0};
        vecs[3] = '{24'h045162, 6'b000000, 1'b1, 48'hBF_99_92_F9_82_A4};
        vecs[4] = '{24'h045162, 6'b000100, 1'b0, 48'hFF_99_92_79_82_A4};
        vecs[5] = '{24'h987360, 6'b000000, 1'b1, 48'h90_80_F8_B0_82_C0};
        vecs[6] = '{24'h000000, 6'b000000, 1'b1, 48'hFF_FF_FF_FF_BF_C0};
        vecs[7] = '{24'h000000, 6'b100011, 1'b1, 48'h7F_FF_FF_FF_3F_40};
        vecs[8] = '{24'h00000F, 6'b000000, 1'b1, 48'hFF_FF_FF_FF_BF_FF};
        vecs[9] = '{24'h100000, 6'b000000, 1'b0, 48'hF9_C0_C0_C0_C0_C0};

        // Reset state and power-up frame (snapshot cleared -> shows 0).
        rst_n  = 1'b0;
        seg_en = 1'b1;
        setv(24'h987360, 6'b000000, 1'b0);
        #12;
        chk("rst_sel", {2'b00, sel}, 8'h00);
        chk("rst_seg", seg, 8'hFF);
        @(negedge clk);
        rst_n = 1'b1;
        run_frame("boot_zero", 48'hFF_FF_FF_FF_FF_C0);
        run_frame("boot_first", 48'h90_80_F8_B0_82_C0);

        for (int v = 0; v < 10; v++) begin
            seg_en = 1'b0;
            setv(vecs[v].dig, vecs[v].pt, vecs[v].sg);
            tick();
            chk("dark_sel", {2'b00, sel}, 8'h00);
            chk("dark_seg", seg, 8'hFF);
            seg_en = 1'b1;
            run_frame($sformatf("vec%0d", v), vecs[v].exp);
        end

        // Input change mid-frame must wait for the next snapshot.
        seg_en = 1'b0;
        setv(24'h125479, 6'b000000, 1'b0);
        tick();
        seg_en = 1'b1;
        for (int e = 0; e < 60; e++) begin
            logic [47:0] ex;
            ex = (e < 30) ? 48'hF9_A4_92_99_F8_90 : 48'hFF_FF_A4_80_F8_99;
            tick();
            chk("midchg_sel", {2'b00, sel}, {2'b00, 6'b000001 << ((e % 30) / 5)});
            chk("midchg_seg", seg, ex[8*((e % 30)/5) +: 8]);
            if (e == 10) setv(24'h002874, 6'b000000, 1'b0);
        end

        // seg_en drop at idx 3, then re-enable restarts at idx 0.
        for (int e = 0; e < 16; e++) tick();
        chk("pre_off_sel", {2'b00, sel}, 8'h08);
        seg_en = 1'b0;
        tick();
        chk("off_sel", {2'b00, sel}, 8'h00);
        chk("off_seg", seg, 8'hFF);
        tick();
        seg_en = 1'b1;
        tick();
        chk("reen_sel", {2'b00, sel}, 8'h01);
        chk("reen_seg", seg, 8'h99);
        for (int e = 0; e < 5; e++) tick();
        chk("reen_idx1_sel", {2'b00, sel}, 8'h02);
        chk("reen_idx1_seg", seg, 8'hF8);

        // Asynchronous reset mid-dwell, no clock edge in between.
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_sel", {2'b00, sel}, 8'h00);
        chk("async_rst_seg", seg, 8'hFF);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("post_rst_sel", {2'b00, sel}, 8'h01);
        chk("post_rst_seg", seg, 8'hC0);
        tick();
        chk("post_rst_seg2", seg, 8'hC0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
